// File: rtl/gcd_pkg.sv
// gcd_pkg: shared state, comparator encoding and default width for the GCD engine
package gcd_pkg;
    localparam int GCD_WIDTH = 16;
    typedef enum logic [2:0] {IDLE, LOAD_A, LOAD_B, CALC, DONE} state_e;
    typedef enum logic [1:0] {CMP_EQ, CMP_LT, CMP_GT} cmp_e;
endpackage

// File: rtl/gcd_datapath.sv
// gcd_datapath: A/B operand registers, operand muxes, subtractor and comparator
module gcd_datapath
    import gcd_pkg::*;
#(
    parameter int WIDTH = GCD_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             ld_a_i,
    input  logic             ld_b_i,
    input  logic             sel_in_i,
    input  logic             sel1_i,
    input  logic             sel2_i,
    input  logic [WIDTH-1:0] data_in_i,
    output logic [WIDTH-1:0] a_o,
    output cmp_e             cmp_o,
    output logic             a_zero_o,
    output logic             b_zero_o
);
    logic [WIDTH-1:0] a_q, b_q, a_d, b_d, diff, nxt;
    // sel1/sel2 both high give B-A, which also yields B when A is zero
    assign diff = (sel1_i ? b_q : a_q) - (sel2_i ? a_q : b_q);
    assign nxt  = sel_in_i ? data_in_i : diff;
    assign a_d  = ld_a_i ? nxt : a_q;
    assign b_d  = ld_b_i ? nxt : b_q;
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            a_q <= '0;
            b_q <= '0;
        end else begin
            a_q <= a_d;
            b_q <= b_d;
        end
    end
    assign cmp_o    = (a_q == b_q) ? CMP_EQ : (a_q > b_q) ? CMP_GT : CMP_LT;
    assign a_zero_o = (a_q == '0);
    assign b_zero_o = (b_q == '0);
    assign a_o      = a_q;
endmodule

// File: rtl/gcd_engine.sv
// gcd_engine: subtract-and-compare GCD controller; GCD_ITER_COUNT_EN adds a saturating iter_count output
module gcd_engine
    import gcd_pkg::*;
#(
    parameter int WIDTH = GCD_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] data_in,
`ifdef GCD_ITER_COUNT_EN
    output logic [15:0]      iter_count,
`endif
    output logic [WIDTH-1:0] gcd_out,
    output logic             done,
    output logic             busy
);
    state_e state_q, state_d;
    logic   done_q, busy_q, ld_a, ld_b, sel_in, sel1, sel2, a_zero, b_zero, step;
    cmp_e   cmp;

    gcd_datapath #(.WIDTH(WIDTH)) u_dp (
        .clk       (clk),
        .rst_n     (rst_n),
        .ld_a_i    (ld_a),
        .ld_b_i    (ld_b),
        .sel_in_i  (sel_in),
        .sel1_i    (sel1),
        .sel2_i    (sel2),
        .data_in_i (data_in),
        .a_o       (gcd_out),
        .cmp_o     (cmp),
        .a_zero_o  (a_zero),
        .b_zero_o  (b_zero)
    );

    assign step = (state_q == CALC) && (cmp != CMP_EQ) && !b_zero && !a_zero;

    always_comb begin
        state_d = state_q;
        ld_a    = 1'b0;
        ld_b    = 1'b0;
        sel_in  = 1'b0;
        sel1    = 1'b0;
        sel2    = 1'b0;
        case (state_q)
            IDLE:   state_d = start ? LOAD_A : IDLE;
            LOAD_A: begin
                ld_a    = 1'b1;
                sel_in  = 1'b1;
                state_d = LOAD_B;
            end
            LOAD_B: begin
                ld_b    = 1'b1;
                sel_in  = 1'b1;
                state_d = CALC;
            end
            CALC: begin
                if (cmp == CMP_EQ || b_zero) begin
                    state_d = DONE;
                end else if (a_zero) begin
                    ld_a    = 1'b1;
                    sel1    = 1'b1;
                    sel2    = 1'b1;
                    state_d = DONE;
                end else if (cmp == CMP_GT) begin
                    ld_a = 1'b1;
                end else begin
                    ld_b = 1'b1;
                    sel1 = 1'b1;
                    sel2 = 1'b1;
                end
            end
            DONE:    state_d = start ? DONE : IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            done_q  <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            done_q  <= (state_d == DONE);
            busy_q  <= (state_d == LOAD_A) || (state_d == LOAD_B) || (state_d == CALC);
        end
    end

    assign done = done_q;
    assign busy = busy_q;

`ifdef GCD_ITER_COUNT_EN
    logic [15:0] iter_q, iter_d;
    assign iter_d = (state_q == LOAD_A) ? 16'd0 :
                    (step && iter_q != 16'hFFFF) ? iter_q + 16'd1 : iter_q;
    always_ff @(posedge clk) begin
        if (!rst_n) iter_q <= 16'd0;
        else        iter_q <= iter_d;
    end
    assign iter_count = iter_q;
`else
    logic unused_step;
    assign unused_step = step;
`endif
endmodule

// File: tb/tb_gcd_engine.sv
// tb_gcd_engine: directed self-checking bench for gcd_engine
module tb_gcd_engine;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [15:0] data_in = '0;
    logic [15:0] gcd_out;
    logic        done, busy;
`ifdef GCD_ITER_COUNT_EN
    logic [15:0] iter_count;
`endif
    int errors = 0;
    int checks = 0;

    gcd_engine dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .data_in    (data_in),
`ifdef GCD_ITER_COUNT_EN
        .iter_count (iter_count),
`endif
        .gcd_out    (gcd_out),
        .done       (done),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    // Returns from IDLE-or-DONE through a full operation; cyc counts CALC edges until done
    task automatic do_op(input logic [15:0] a, input logic [15:0] b, output int cyc, output logic busy_calc);
        @(negedge clk) start = 1'b0;
        @(negedge clk);
        data_in = a;
        start   = 1'b1;
        @(posedge clk);
        @(posedge clk);
        #1 data_in = b;
        @(posedge clk);
        #1 busy_calc = busy;
        cyc = 0;
        while (cyc < 70000) begin
            @(posedge clk);
            cyc++;
            #1;
            if (done) break;
        end
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checks++; if (gcd_out !== 16'd0) begin errors++; $display("FAIL reset_gcd_out got=%0d exp=0", gcd_out); end
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done got=%b exp=0", done); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b exp=0", busy); end
        @(negedge clk) rst_n = 1'b1;
    endtask

    task automatic test_basic;
        int cyc; logic bc;
        do_op(16'd143, 16'd78, cyc, bc);
        checks++; if (bc !== 1'b1) begin errors++; $display("FAIL basic_busy got=%b exp=1", bc); end
        checks++; if (gcd_out !== 16'd13) begin errors++; $display("FAIL basic_gcd got=%0d exp=13", gcd_out); end
        checks++; if (done !== 1'b1) begin errors++; $display("FAIL basic_done got=%b exp=1", done); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL basic_busy_done got=%b exp=0", busy); end
        checks++; if (cyc !== 7) begin errors++; $display("FAIL basic_latency got=%0d exp=7", cyc); end
`ifdef GCD_ITER_COUNT_EN
        checks++; if (iter_count !== 16'd6) begin errors++; $display("FAIL basic_iter got=%0d exp=6", iter_count); end
`endif
    endtask

    task automatic test_equal;
        int cyc; logic bc;
        do_op(16'd50, 16'd50, cyc, bc);
        checks++; if (gcd_out !== 16'd50) begin errors++; $display("FAIL equal_gcd got=%0d exp=50", gcd_out); end
        checks++; if (cyc !== 1) begin errors++; $display("FAIL equal_latency got=%0d exp=1", cyc); end
`ifdef GCD_ITER_COUNT_EN
        checks++; if (iter_count !== 16'd0) begin errors++; $display("FAIL equal_iter got=%0d exp=0", iter_count); end
`endif
    endtask

    task automatic test_restart;
        int cyc; logic bc;
        do_op(16'd17, 16'd5, cyc, bc);
        checks++; if (gcd_out !== 16'd1) begin errors++; $display("FAIL r17_5_gcd got=%0d exp=1", gcd_out); end
        checks++; if (cyc !== 7) begin errors++; $display("FAIL r17_5_latency got=%0d exp=7", cyc); end
        @(negedge clk) start = 1'b0;
        @(posedge clk);
        #1;
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL drop_done got=%b exp=0", done); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL drop_busy got=%b exp=0", busy); end
        repeat (2) @(posedge clk);
        #1;
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL idle_busy got=%b exp=0", busy); end
        do_op(16'd48, 16'd18, cyc, bc);
        checks++; if (gcd_out !== 16'd6) begin errors++; $display("FAIL r48_18_gcd got=%0d exp=6", gcd_out); end
        checks++; if (cyc !== 5) begin errors++; $display("FAIL r48_18_latency got=%0d exp=5", cyc); end
`ifdef GCD_ITER_COUNT_EN
        checks++; if (iter_count !== 16'd4) begin errors++; $display("FAIL r48_18_iter got=%0d exp=4", iter_count); end
`endif
    endtask

    task automatic test_zero;
        int cyc; logic bc;
        do_op(16'd0, 16'd36, cyc, bc);
        checks++; if (gcd_out !== 16'd36) begin errors++; $display("FAIL z0_36_gcd got=%0d exp=36", gcd_out); end
        checks++; if (cyc !== 1) begin errors++; $display("FAIL z0_36_latency got=%0d exp=1", cyc); end
        do_op(16'd36, 16'd0, cyc, bc);
        checks++; if (gcd_out !== 16'd36) begin errors++; $display("FAIL z36_0_gcd got=%0d exp=36", gcd_out); end
        checks++; if (cyc !== 1) begin errors++; $display("FAIL z36_0_latency got=%0d exp=1", cyc); end
        do_op(16'd0, 16'd0, cyc, bc);
        checks++; if (gcd_out !== 16'd0) begin errors++; $display("FAIL z0_0_gcd got=%0d exp=0", gcd_out); end
        checks++; if (cyc !== 1) begin errors++; $display("FAIL z0_0_latency got=%0d exp=1", cyc); end
    endtask

    task automatic test_reset_mid_calc;
        int cyc; logic bc;
        @(negedge clk) start = 1'b0;
        @(negedge clk);
        data_in = 16'd143;
        start   = 1'b1;
        @(posedge clk);
        @(posedge clk);
        #1 data_in = 16'd78;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        start = 1'b0;
        @(posedge clk);
        #1;
        checks++; if (gcd_out !== 16'd0) begin errors++; $display("FAIL midrst_gcd got=%0d exp=0", gcd_out); end
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL midrst_done got=%b exp=0", done); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL midrst_busy got=%b exp=0", busy); end
        @(negedge clk) rst_n = 1'b1;
        do_op(16'd21, 16'd14, cyc, bc);
        checks++; if (gcd_out !== 16'd7) begin errors++; $display("FAIL r21_14_gcd got=%0d exp=7", gcd_out); end
        checks++; if (cyc !== 3) begin errors++; $display("FAIL r21_14_latency got=%0d exp=3", cyc); end
    endtask

    task automatic test_max_hold;
        int cyc; logic bc;
        do_op(16'd65535, 16'd65534, cyc, bc);
        checks++; if (gcd_out !== 16'd1) begin errors++; $display("FAIL max_gcd got=%0d exp=1", gcd_out); end
        checks++; if (cyc !== 65535) begin errors++; $display("FAIL max_latency got=%0d exp=65535", cyc); end
`ifdef GCD_ITER_COUNT_EN
        checks++; if (iter_count !== 16'd65534) begin errors++; $display("FAIL max_iter got=%0d exp=65534", iter_count); end
`endif
        for (int i = 0; i < 10; i++) begin
            @(posedge clk);
            #1;
            checks++; if (done !== 1'b1 || gcd_out !== 16'd1) begin errors++; $display("FAIL hold_%0d done=%b gcd=%0d exp done=1 gcd=1", i, done, gcd_out); end
        end
    endtask

    initial begin
        test_reset;
        test_basic;
        test_equal;
        test_restart;
        test_zero;
        test_reset_mid_calc;
        test_max_hold;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/gcd_engine.md
Name: gcd_engine

Overview:
- Iterative GCD unit using the subtract-and-compare (Euclid) method on two unsigned operands.
- Operands are loaded serially over one shared data_in bus: A on the first load cycle after start, B on the next.
- Internal split: FSM controller plus datapath (A/B registers, comparator, subtractor, operand muxes).
- Result is presented on gcd_out with a level done flag.

Parameters:
- WIDTH, 16, operand/result bit width (unsigned).

Ports:
- clk  in  1  rising-edge clock; the only clock.
- rst_n  in  1  synchronous active-low reset.
- start  in  1  level request; sampled only in IDLE and DONE.
- data_in  in  WIDTH  operand bus; A then B on consecutive load cycles.
- gcd_out  out  WIDTH  always shows the A register; final value valid when done=1.
- done  out  1  registered; high while in DONE.
- busy  out  1  registered; high in LOAD_A, LOAD_B and CALC.

Behaviour:
- Reset (rst_n=0 at posedge): state=IDLE, A=0, B=0, done=0, busy=0. Reset has priority over everything, including mid-computation; the next operation starts from IDLE.
- States: IDLE, LOAD_A, LOAD_B, CALC, DONE.
- IDLE: if start=1 at posedge -> LOAD_A; otherwise stay. data_in is ignored.
- LOAD_A: A<=data_in, then -> LOAD_B. This is the first posedge after start was seen.
- LOAD_B: B<=data_in, then -> CALC.
- CALC, one decision per cycle, evaluated in this priority order:
  - A==B -> DONE, no register change.
  - B==0 -> DONE, A unchanged.
  - A==0 -> A<=B, then -> DONE.
  - A>B -> A<=A-B, stay in CALC.
  - A<B -> B<=B-A, stay in CALC.
- Arithmetic: unsigned WIDTH-bit compare and subtract. The larger operand minus the smaller never underflows.
- Zero operands: gcd(x,0)=gcd(0,x)=x and gcd(0,0)=0. The loop always terminates.
- DONE: done=1, busy=0, gcd_out holds the result.
  - Stay in DONE while start=1.
  - start=0 -> IDLE; done drops on that same transition.
  - A new operation therefore needs start to go low and then high again.
- Outputs are registered; done and busy take the value of the state they belong to, updated at the same posedge as the state register.
- Latency: start sampled at edge t0. A is loaded at t0+1, B at t0+2. CALC decisions occur at t0+3 onward. done is high after the edge that makes the equal/zero decision, i.e. t0+3+N, where N is the number of subtraction steps.
- data_in contents in IDLE, CALC and DONE have no effect.

Optional Feature:
- Macro GCD_ITER_COUNT_EN.
- Defined:
  - Extra output port iter_count [15:0].
  - Cleared in LOAD_A; incremented on every CALC subtraction step; saturates at 16'hFFFF.
  - Holds its value in DONE; reset value 0.
- Undefined: port and counter are absent; all other behaviour is identical.

Decomposition:
- Package gcd_pkg:
  - State enum (IDLE, LOAD_A, LOAD_B, CALC, DONE).
  - Default WIDTH constant.
  - Comparator result encoding (lt/gt/eq).
- Sub-module gcd_datapath:
  - A and B registers with load enables.
  - Mux select between data_in and subtractor output.
  - Comparator producing lt/gt/eq and a zero flag for each register.
- The top level (gcd_engine) holds the controller FSM, which drives ldA, ldB, sel1, sel2 and sel_in to the datapath.

Test Plan:
- Reset, then start=1 (held), A=143, B=78 -> gcd_out=13 and done=1 exactly 6 subtraction cycles after B loads. With GCD_ITER_COUNT_EN, iter_count=6.
- A=50, B=50 -> done on the first CALC cycle, gcd_out=50, no subtractions.
- A=17, B=5 -> gcd_out=1. Then drop start: done falls and the FSM returns to IDLE. Start again with A=48, B=18 -> gcd_out=6.
- Zero cases:
  - A=0, B=36 -> gcd_out=36.
  - A=36, B=0 -> gcd_out=36.
  - A=0, B=0 -> gcd_out=0.
  - Each finishes in one CALC cycle.
- rst_n=0 mid-CALC (A=143, B=78 in progress) -> at the next posedge A=B=0, done=0, busy=0, state IDLE. A fresh run with A=21, B=14 then yields 7.
- A=65535, B=65534 -> gcd_out=1, no overflow. Hold start=1 in DONE for 10 cycles -> done and result remain stable.
